// File: rtl/usart_rx_hash_loader.sv
// 8N1 UART receiver that assembles sixteen good bytes into a 128-bit target digest.
// Byte strobe one cycle after mid-stop sample; no backpressure, the line cannot be stalled.
module usart_rx_hash_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    output logic [7:0]   rx_byte,
    output logic         rx_strobe,
    output logic         frame_err,
    output logic [127:0] hash_out,
    output logic         hash_valid,
    output logic         hash_update,
    output logic         rx_led
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TMO_LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LIMIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         state_q, state_d;
    logic           sync_q, sync_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [119:0]   acc_q, acc_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     rx_byte_q, rx_byte_d;
    logic           rx_strobe_q, rx_strobe_d, frame_err_q, frame_err_d;
    logic [127:0]   hash_q, hash_d;
    logic           hash_valid_q, hash_valid_d, hash_update_q, hash_update_d;
    logic           rx_led_q, rx_led_d;
    logic           fall;

    assign fall = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fall) state_d = S_START;
            S_START: if (baud_q == HALF_CNT) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:  if (baud_q == FULL_CNT && bit_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (baud_q == FULL_CNT) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sync_d        = rx;
        rx_s_d        = sync_q;
        rx_prev_d     = rx_s_q;
        baud_d        = baud_q + 1'b1;
        bit_d         = bit_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        tmo_d         = tmo_q;
        rx_byte_d     = rx_byte_q;
        rx_strobe_d   = 1'b0;
        frame_err_d   = 1'b0;
        hash_d        = hash_q;
        hash_valid_d  = hash_valid_q;
        hash_update_d = 1'b0;
        rx_led_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: baud_d = '0;
            S_START: if (baud_q == HALF_CNT) begin
                baud_d = '0;
                bit_d  = 3'd0;
            end
            S_DATA: if (baud_q == FULL_CNT) begin
                baud_d  = '0;
                shift_d = {rx_s_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
            end
            S_STOP: if (baud_q == FULL_CNT) begin
                baud_d = '0;
                if (rx_s_q) begin
                    rx_byte_d   = shift_q;
                    rx_strobe_d = 1'b1;
                    acc_d       = {acc_q[111:0], shift_q};
                    cnt_d       = cnt_q + 4'd1;
                    // 16th byte: publish the whole digest at once, count wraps to 0
                    if (cnt_q == 4'd15) begin
                        hash_d        = {acc_q, shift_q};
                        hash_valid_d  = 1'b1;
                        hash_update_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    cnt_d       = 4'd0;
                    acc_d       = '0;
                end
            end
            default: baud_d = '0;
        endcase
        // Inter-byte timeout only runs while a partial digest waits in IDLE
        if (cnt_q == 4'd0) begin
            tmo_d = '0;
        end else if (state_q == S_IDLE) begin
            if (fall) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d = '0;
                cnt_d = 4'd0;
                acc_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            baud_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            cnt_q         <= '0;
            acc_q         <= '0;
            tmo_q         <= '0;
            rx_byte_q     <= '0;
            rx_strobe_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            hash_q        <= '0;
            hash_valid_q  <= 1'b0;
            hash_update_q <= 1'b0;
            rx_led_q      <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            rx_s_q        <= rx_s_d;
            rx_prev_q     <= rx_prev_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            tmo_q         <= tmo_d;
            rx_byte_q     <= rx_byte_d;
            rx_strobe_q   <= rx_strobe_d;
            frame_err_q   <= frame_err_d;
            hash_q        <= hash_d;
            hash_valid_q  <= hash_valid_d;
            hash_update_q <= hash_update_d;
            rx_led_q      <= rx_led_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_strobe   = rx_strobe_q;
    assign frame_err   = frame_err_q;
    assign hash_out    = hash_q;
    assign hash_valid  = hash_valid_q;
    assign hash_update = hash_update_q;
    assign rx_led      = rx_led_q;
endmodule

// File: tb/tb_usart_rx_hash_loader.sv
// Bench for usart_rx_hash_loader: directed and random UART traffic against a byte-queue digest model.
module tb_usart_rx_hash_loader;
    localparam int CPB = 16;
    localparam int TOB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx = 1'b1;
    logic [7:0]   rx_byte;
    logic         rx_strobe, frame_err, hash_valid, hash_update, rx_led;
    logic [127:0] hash_out;

    usart_rx_hash_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .rx_byte(rx_byte), .rx_strobe(rx_strobe), .frame_err(frame_err),
        .hash_out(hash_out), .hash_valid(hash_valid), .hash_update(hash_update),
        .rx_led(rx_led)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: event counts plus two invariants on hash_out/hash_update
    int           n_strobe, n_ferr, n_upd, n_bad_chg, n_upd_nostrobe;
    logic [127:0] prev_hash;
    always @(negedge clk) begin
        if (reset) begin
            n_strobe = 0; n_ferr = 0; n_upd = 0; n_bad_chg = 0; n_upd_nostrobe = 0;
            prev_hash = hash_out;
        end else begin
            if (rx_strobe) n_strobe++;
            if (frame_err) n_ferr++;
            if (hash_update) begin
                n_upd++;
                if (!rx_strobe) n_upd_nostrobe++;
            end
            if (hash_out !== prev_hash && !hash_update) n_bad_chg++;
            prev_hash = hash_out;
        end
    end

    // Reference model: pending good bytes, digest formed when sixteen are queued
    logic [7:0]   pend[$];
    logic [127:0] exp_hash;
    logic         exp_valid;
    int           e_strobe, e_ferr, e_upd;
    logic [7:0]   e_last;
    logic         led_mid;

    task automatic model_reset();
        pend.delete();
        exp_hash = '0; exp_valid = 1'b0;
        e_strobe = 0; e_ferr = 0; e_upd = 0; e_last = 8'h00;
    endtask

    task automatic model_good(input logic [7:0] b);
        e_strobe++;
        e_last = b;
        pend.push_back(b);
        if (pend.size() == 16) begin
            exp_hash = '0;
            foreach (pend[i]) exp_hash = {exp_hash[119:0], pend[i]};
            exp_valid = 1'b1;
            e_upd++;
            pend.delete();
        end
    endtask

    task automatic model_gap(input int bits);
        if (bits > TOB) pend.delete();
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == 4) begin
                #1 led_mid = rx_led;
            end
            repeat (CPB) @(posedge clk);
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
    endtask

    task automatic tx_good(input logic [7:0] b, input int gap);
        send_byte(b, 1'b1);
        model_good(b);
        idle(gap);
        model_gap(gap);
    endtask

    task automatic tx_bad(input logic [7:0] b);
        send_byte(b, 1'b0);
        e_ferr++;
        pend.delete();
        idle(1);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, ".hash_out"},   hash_out, exp_hash);
        chk({tag, ".hash_valid"}, 128'(hash_valid), 128'(exp_valid));
        chk({tag, ".rx_byte"},    128'(rx_byte), 128'(e_last));
        chk({tag, ".strobes"},    128'(n_strobe), 128'(e_strobe));
        chk({tag, ".frame_errs"}, 128'(n_ferr), 128'(e_ferr));
        chk({tag, ".updates"},    128'(n_upd), 128'(e_upd));
        chk({tag, ".hash_glitch"}, 128'(n_bad_chg + n_upd_nostrobe), 128'(0));
    endtask

    task automatic do_reset();
        rx = 1'b1;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.led",    128'(rx_led), 128'(0));
        chk("reset.strobe", 128'(rx_strobe), 128'(0));
        chk("reset.ferr",   128'(frame_err), 128'(0));
        chk("reset.update", 128'(hash_update), 128'(0));
        chk("reset.hash",   hash_out, 128'(0));
        chk("reset.valid",  128'(hash_valid), 128'(0));
        chk("reset.byte",   128'(rx_byte), 128'(0));
        reset = 1'b0;
        idle(1);
    endtask

    logic [7:0] vec [16];
    logic [7:0] b;

    initial begin
        vec = '{8'h82, 8'hcf, 8'h9f, 8'ha6, 8'h47, 8'hdd, 8'h1b, 8'h3f,
                8'hbd, 8'h9d, 8'he7, 8'h1b, 8'hbf, 8'hb8, 8'h3f, 8'hb2};
        do_reset();
        check_state("reset");

        // Single byte
        tx_good(8'h55, 2);
        chk("single.led_mid", 128'(led_mid), 128'(1));
        chk("single.led_idle", 128'(rx_led), 128'(0));
        chk("single.byte", 128'(rx_byte), 128'h55);
        check_state("single");
        idle(6); model_gap(6);

        // Full digest, back to back
        for (int i = 0; i < 15; i++) tx_good(vec[i], 0);
        chk("digest.partial", hash_out, 128'(0));
        tx_good(vec[15], 1);
        chk("digest.value", hash_out, 128'h82cf9fa647dd1b3fbd9de71bbfb83fb2);
        check_state("digest");

        // Framing error discards the partial digest
        for (int i = 0; i < 3; i++) tx_good(8'($urandom), 0);
        tx_bad(8'hA5);
        for (int i = 0; i < 16; i++) tx_good(8'h11, 0);
        chk("ferr.value", hash_out, {16{8'h11}});
        check_state("ferr");

        // Start-bit glitch
        rx = 1'b0;
        repeat (4) @(posedge clk);
        idle(2);
        check_state("glitch");
        tx_good(8'h3C, 1);
        check_state("glitch_after");
        idle(6); model_gap(6);

        // Inter-byte timeout, then a gap below the limit
        for (int i = 0; i < 4; i++) tx_good(8'($urandom), 0);
        tx_good(8'($urandom), 5);
        for (int i = 0; i < 16; i++) tx_good(8'h22, 0);
        chk("timeout.value", hash_out, {16{8'h22}});
        check_state("timeout");
        for (int i = 0; i < 4; i++) tx_good(8'($urandom), 0);
        tx_good(8'($urandom), 3);
        for (int i = 0; i < 11; i++) tx_good(8'($urandom), 0);
        check_state("short_gap");

        // Reset in the middle of byte 9, bit 3
        for (int i = 0; i < 8; i++) tx_good(8'($urandom), 0);
        b = 8'($urandom);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = b[3];
        repeat (CPB / 2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midreset.hash",  hash_out, 128'(0));
        chk("midreset.valid", 128'(hash_valid), 128'(0));
        chk("midreset.led",   128'(rx_led), 128'(0));
        chk("midreset.byte",  128'(rx_byte), 128'(0));
        do_reset();
        for (int i = 0; i < 16; i++) tx_good(8'($urandom), 0);
        check_state("after_reset");

        // Random traffic: short gaps, occasional framing errors and timeouts
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 20; k++) begin
                int ev;
                ev = int'($urandom_range(0, 11));
                if (ev == 0) tx_bad(8'($urandom));
                else if (ev == 1) tx_good(8'($urandom), 6);
                else tx_good(8'($urandom), int'($urandom_range(0, 2)));
            end
            check_state($sformatf("random%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
